// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings and default sizes for the sequential shift unit.
package seq_shift_unit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  // Operation encodings carried on ctrl_op.
  typedef enum logic [1:0] {
    SHIFT_OP_SLL = 2'b00,
    SHIFT_OP_SRA = 2'b01,
    SHIFT_OP_SRL = 2'b10,
    SHIFT_OP_ROR = 2'b11
  } shift_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Start/result bus between the pipeline (master) and the shift unit (slave).
interface seq_shift_unit_if import seq_shift_unit_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
);

  logic               ctrl_shift;
  logic [1:0]         ctrl_op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   data_out;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_shift, ctrl_op, shamt, data_in,
    input  data_out, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_shift, ctrl_op, shamt, data_in,
    output data_out, data_resultRDY, busy
  );

endinterface

// File: rtl/seq_shift_unit_shift1.sv
// One-position shift/rotate of a WIDTH-bit word; purely combinational.
module shift1_unit import seq_shift_unit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] y
);

  // Select the single-step shift for the requested operation.
  always_comb begin
    // NOTE: y gets a default before the case so no path can infer a latch.
    y = w;
    case (op)
      SHIFT_OP_SLL: y = {w[WIDTH-2:0], 1'b0};
      SHIFT_OP_SRA: y = {w[WIDTH-1], w[WIDTH-1:1]};
      SHIFT_OP_SRL: y = {1'b0, w[WIDTH-1:1]};
      SHIFT_OP_ROR: y = {w[0], w[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: captures an operand, shifts one bit per clock,
// then pulses data_resultRDY for one cycle with the result on data_out.
module seq_shift_unit import seq_shift_unit_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic            clock,
  input  logic            reset,
  seq_shift_unit_if.slave bus
);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_data_out, w_data_out_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [SHAMT_W-1:0] r_count, w_count_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic               r_rdy;
  logic               r_busy;

  shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
    .op (r_op),
    .w  (r_work),
    .y  (w_shifted)
  );

  // Next-state, datapath and result selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_work_nxt     = r_work;
    w_count_nxt    = r_count;
    w_op_nxt       = r_op;
    w_data_out_nxt = r_data_out;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.ctrl_shift) begin
          w_work_nxt  = bus.data_in;
          w_op_nxt    = bus.ctrl_op;
          w_count_nxt = bus.shamt;
          if (bus.shamt == '0) begin
            // Zero-length shift completes at the capture edge.
            w_data_out_nxt = bus.data_in;
            w_state_nxt    = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_work_nxt  = w_shifted;
        w_count_nxt = r_count - 1'b1;
        if (r_count == SHAMT_W'(1)) begin
          w_data_out_nxt = w_shifted;
          w_state_nxt    = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; busy/rdy are registered decodes of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_work     <= '0;
      r_count    <= '0;
      r_op       <= '0;
      r_data_out <= '0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_work     <= w_work_nxt;
      r_count    <= w_count_nxt;
      r_op       <= w_op_nxt;
      r_data_out <= w_data_out_nxt;
      r_rdy      <= (w_state_nxt == ST_DONE);
      r_busy     <= (w_state_nxt == ST_BUSY);
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule
